mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/byte_ram.sv | 26 ++
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: access widths, FSM states and the
// default memory-mapped GPIO address.
package defs;

  typedef enum logic [1:0] {
    OP_BYTE = 2'b00,
    OP_HALF = 2'b01,
    OP_WORD = 2'b10
  } oplen_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RD     = 2'b01,
    S_RESP   = 2'b10,
    S_WR_ACK = 2'b11
  } resp_state_t;

  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module byte_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving an instruction-fetch port and a load/store data port
// from one on-chip byte-writable RAM plus a single memory-mapped GPIO register.
module mem_responder
  import defs::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] GPIO_ADDR = GPIO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_enable,
  input  logic [31:0] instr_addr,
  output logic        instr_valid,
  output logic [31:0] instr_result,
  input  logic        data_enable,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [1:0]  data_oplen,
  input  logic        data_unsigned,
  input  logic [31:0] data_wdata,
  output logic        data_valid,
  output logic [31:0] data_result,
  output logic [31:0] gpio,
  output logic        err_misaligned
);

  localparam int AW = $clog2(MEM_WORDS);

  function automatic logic misaligned(input logic [1:0] op, input logic [1:0] a);
    case (op)
      OP_BYTE: misaligned = 1'b0;
      OP_HALF: misaligned = a[0];
      OP_WORD: misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] op, input logic [1:0] a);
    case (op)
      OP_BYTE: lane_en = 4'b0001 << a;
      OP_HALF: lane_en = a[1] ? 4'b1100 : 4'b0011;
      OP_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] op, input logic [31:0] w);
    case (op)
      OP_BYTE: lane_data = {4{w[7:0]}};
      OP_HALF: lane_data = {2{w[15:0]}};
      default: lane_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] op,
                                           input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_BYTE: load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
      OP_HALF: load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  resp_state_t state_q, state_d;
  logic        instr_valid_q, data_valid_q;
  logic [31:0] instr_result_q, data_result_q;
  logic [31:0] gpio_q;
  logic        err_q;

  // Request context captured in IDLE; only meaningful in the following RD cycle.
  logic        is_data_q;
  logic [1:0]  op_q;
  logic [1:0]  lo_q;
  logic        uns_q;
  logic        mis_q;
  logic        hit_q;

  logic        take_d, take_i;
  logic [31:0] req_addr;
  logic        mis_d, hit_d;
  logic        store_ok;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] load_val, fetch_val;

  assign take_d   = (state_q == S_IDLE) && data_enable;
  assign take_i   = (state_q == S_IDLE) && !data_enable && instr_enable;
  assign req_addr = data_enable ? data_addr : instr_addr;
  assign mis_d    = misaligned(data_oplen, data_addr[1:0]);
  assign hit_d    = (req_addr == GPIO_ADDR);

  // Gating with rst_n keeps a store that coincides with reset from committing.
  assign store_ok = take_d && data_we && !mis_d && rst_n;
  assign ram_we   = (store_ok && !hit_d) ? lane_en(data_oplen, data_addr[1:0]) : 4'b0000;

  byte_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .addr_i  (req_addr[AW+1:2]),
    .we_i    (ram_we),
    .wdata_i (lane_data(data_oplen, data_wdata)),
    .rdata_o (ram_rdata)
  );

  assign load_val  = mis_q ? 32'h0 : load_ext(hit_q ? gpio_q : ram_rdata, op_q, lo_q, uns_q);
  assign fetch_val = hit_q ? 32'h0000_0013 : ram_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_d)      state_d = data_we ? S_WR_ACK : S_RD;
        else if (take_i) state_d = S_RD;
      end
      S_RD:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      instr_valid_q  <= 1'b0;
      data_valid_q   <= 1'b0;
      instr_result_q <= 32'h0;
      data_result_q  <= 32'h0;
      gpio_q         <= 32'h0;
      err_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= (state_q == S_RD) && !is_data_q;
      data_valid_q  <= ((state_q == S_RD) && is_data_q) || (take_d && data_we);
      if (state_q == S_RD) begin
        if (is_data_q) data_result_q  <= load_val;
        else           instr_result_q <= fetch_val;
      end
      if (take_d && data_we) data_result_q <= 32'h0;
      if (take_d && mis_d) err_q <= 1'b1;
      if (store_ok && hit_d && (data_oplen == OP_WORD)) gpio_q <= data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      is_data_q <= data_enable;
      op_q      <= data_oplen;
      lo_q      <= data_addr[1:0];
      uns_q     <= data_unsigned;
      mis_q     <= data_enable && mis_d;
      hit_q     <= hit_d;
    end
  end

  assign instr_valid    = instr_valid_q;
  assign instr_result   = instr_result_q;
  assign data_valid     = data_valid_q;
  assign data_result    = data_result_q;
  assign gpio           = gpio_q;
  assign err_misaligned = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a byte-addressed reference memory predicts
// every response; a monitor pops predictions whenever a valid pulse appears.
module tb_mem_responder;

  localparam int          WORDS = 64;
  localparam int          RAMB  = 4 * WORDS;
  localparam logic [31:0] GPIO  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_enable, instr_valid;
  logic [31:0] instr_addr, instr_result;
  logic        data_enable, data_we, data_unsigned, data_valid;
  logic [31:0] data_addr, data_wdata, data_result;
  logic [1:0]  data_oplen;
  logic [31:0] gpio;
  logic        err_misaligned;

  mem_responder #(.MEM_WORDS(WORDS), .GPIO_ADDR(GPIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_enable(instr_enable), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_result(instr_result),
    .data_enable(data_enable), .data_addr(data_addr), .data_we(data_we),
    .data_oplen(data_oplen), .data_unsigned(data_unsigned), .data_wdata(data_wdata),
    .data_valid(data_valid), .data_result(data_result),
    .gpio(gpio), .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    bit          chk_res;
    int          cyc;
    logic [31:0] gpio;
    bit          err;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int checks = 0;
  int errors = 0;

  // Reference state: byte-addressed memory, GPIO register, sticky error flag.
  logic [7:0]  mem_m [RAMB];
  logic [31:0] gpio_m = 32'h0;
  bit          err_m  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data(input bit we, input logic [1:0] op,
      input logic [31:0] a, input bit uns, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    if ((op == 2'd1 && a[0]) || (op == 2'd2 && a[1:0] != 2'd0) || op == 2'd3) begin
      err_m = 1'b1;
      return 32'h0;
    end
    n = 1 << op;
    if (a == GPIO) begin
      if (we) begin
        if (op == 2'd2) gpio_m = wd;
        return 32'h0;
      end
      v = gpio_m;
    end else if (we) begin
      for (int i = 0; i < n; i++) mem_m[(a + 32'(i)) % RAMB] = wd[8*i +: 8];
      return 32'h0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[(a + 32'(i)) % RAMB];
    end
    if (n == 1) v = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
    if (n == 2) v = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    logic [31:0] v;
    if (a == GPIO) return 32'h0000_0013;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mem_m[(a + 32'(i)) % RAMB];
    return v;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (data_valid) begin
      if (dq.size() == 0) check("data_valid_unexpected", 32'd1, 32'd0);
      else begin
        e = dq.pop_front();
        check("data_latency", 32'(cyc), 32'(e.cyc));
        if (e.chk_res) check("data_result", data_result, e.res);
        check("gpio", gpio, e.gpio);
        check("err_misaligned", {31'h0, err_misaligned}, {31'h0, e.err});
      end
    end
    if (instr_valid) begin
      if (iq.size() == 0) check("instr_valid_unexpected", 32'd1, 32'd0);
      else begin
        e = iq.pop_front();
        check("instr_latency", 32'(cyc), 32'(e.cyc));
        check("instr_result", instr_result, e.res);
      end
    end
  end

  // Issue one request (data, fetch, or both together) and wait for completion.
  task automatic do_req(input bit ud, input bit ui, input bit we, input logic [1:0] op,
                        input logic [31:0] da, input bit uns, input logic [31:0] wd,
                        input logic [31:0] ia);
    exp_t e;
    int   t, dend, k;
    bit   dd, id;
    @(negedge clk);
    t    = cyc;
    dend = t;
    if (ud) begin
      data_enable = 1'b1; data_we = we; data_oplen = op; data_addr = da;
      data_unsigned = uns; data_wdata = wd;
      e.res = model_data(we, op, da, uns, wd);
      e.chk_res = !we;
      dend = t + (we ? 1 : 2);
      e.cyc = dend; e.gpio = gpio_m; e.err = err_m;
      dq.push_back(e);
    end
    if (ui) begin
      instr_enable = 1'b1; instr_addr = ia;
      e.res = model_fetch(ia);
      e.chk_res = 1'b1;
      e.cyc = (ud ? dend + 1 : t) + 2;
      e.gpio = gpio_m; e.err = err_m;
      iq.push_back(e);
    end
    dd = !ud; id = !ui; k = 0;
    while (!(dd && id) && k < 30) begin
      @(negedge clk);
      k++;
      if (data_valid)  begin data_enable  = 1'b0; dd = 1'b1; end
      if (instr_valid) begin instr_enable = 1'b0; id = 1'b1; end
    end
    if (!(dd && id)) begin
      check("request_timeout", 32'd0, 32'd1);
      data_enable = 1'b0; instr_enable = 1'b0;
      dq.delete(); iq.delete();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; data_enable = 1'b0; instr_enable = 1'b0;
    @(negedge clk);
    gpio_m = 32'h0; err_m = 1'b0;
    check("reset_gpio", gpio, 32'h0);
    check("reset_err", {31'h0, err_misaligned}, 32'h0);
    check("reset_data_valid", {31'h0, data_valid}, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a, ia;
    logic [1:0]  op;
    bit          ud, ui;
    rst_n = 1'b0; instr_enable = 1'b0; instr_addr = 32'h0;
    data_enable = 1'b0; data_addr = 32'h0; data_we = 1'b0; data_oplen = 2'b00;
    data_unsigned = 1'b0; data_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("reset_data_valid", {31'h0, data_valid}, 32'h0);
    check("reset_instr_result", instr_result, 32'h0);
    check("reset_data_result", data_result, 32'h0);
    check("reset_gpio", gpio, 32'h0);
    check("reset_err", {31'h0, err_misaligned}, 32'h0);
    rst_n = 1'b1;

    for (int w = 0; w < WORDS; w++)
      do_req(1, 0, 1, 2'd2, 32'(4 * w), 0, $urandom, 32'h0);

    // Store then load back, then byte/half extraction from the same word
    do_req(1, 0, 1, 2'd2, 32'h10, 0, 32'hDEAD_BEEF, 32'h0);
    do_req(1, 0, 0, 2'd2, 32'h10, 0, 32'h0, 32'h0);
    do_req(1, 0, 0, 2'd0, 32'h13, 0, 32'h0, 32'h0);
    do_req(1, 0, 0, 2'd0, 32'h13, 1, 32'h0, 32'h0);
    do_req(1, 0, 0, 2'd1, 32'h10, 0, 32'h0, 32'h0);

    // Simultaneous data and fetch: data first, fetch afterwards
    do_req(1, 1, 0, 2'd2, 32'h10, 0, 32'h0, 32'h0);

    // GPIO register: store, load, fetch, and aliasing RAM word 0 untouched
    do_req(1, 0, 1, 2'd2, GPIO, 0, 32'h0000_00A5, 32'h0);
    do_req(1, 0, 0, 2'd2, GPIO, 0, 32'h0, 32'h0);
    do_req(0, 1, 0, 2'd0, 32'h0, 0, 32'h0, GPIO);
    do_req(1, 0, 0, 2'd2, 32'h0, 0, 32'h0, 32'h0);

    // Misaligned half store, then reset clears error flag and GPIO
    do_req(1, 0, 1, 2'd1, 32'h21, 0, 32'hFFFF_FFFF, 32'h0);
    do_req(1, 0, 0, 2'd2, 32'h20, 0, 32'h0, 32'h0);
    apply_reset();

    // Reset during the RD cycle of a load abandons it
    @(negedge clk);
    data_enable = 1'b1; data_we = 1'b0; data_oplen = 2'd2; data_addr = 32'h10;
    @(negedge clk);
    rst_n = 1'b0; data_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 0, 0, 2'd2, 32'h10, 0, 32'h0, 32'h0);

    // A store whose write edge coincides with reset is dropped
    @(negedge clk);
    data_enable = 1'b1; data_we = 1'b1; data_oplen = 2'd2; data_addr = 32'h30;
    data_wdata = 32'h1234_5678; rst_n = 1'b0;
    @(negedge clk);
    data_enable = 1'b0; rst_n = 1'b1;
    do_req(1, 0, 0, 2'd2, 32'h30, 0, 32'h0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      ud = $urandom_range(0, 1);
      ui = ud ? $urandom_range(0, 1) : 1'b1;
      op = 2'($urandom_range(0, 3));
      a  = $urandom & 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << op) - 32'd1);
      if ($urandom_range(0, 9) == 0) begin a = GPIO; op = 2'd2; end
      ia = $urandom & 32'h7FFF_FFFC;
      if ($urandom_range(0, 9) == 0) ia = GPIO;
      do_req(ud, ui, 1'($urandom_range(0, 1)), op, a, 1'($urandom_range(0, 1)), $urandom, ia);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("data_queue_drained", 32'(dq.size()), 32'd0);
    check("instr_queue_drained", 32'(iq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
